mem_io_responder: RTL

Memory-side responder for the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr in, mem_din / io_buffer_full out). It decodes each bus cycle as a RAM access or a memory-mapped I/O access. It serves RAM reads with one-cycle latency and RAM writes in one cycle, queues UART output bytes in a TX FIFO, and exposes a free-running cycle counter and a program-stop flag. It sits in the top level opposite the CPU's data_cache, in place of the board RAM/UART glue.

---
 rtl/mem_io_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte bus.
// Serves RAM (1-cycle read latency), a UART TX FIFO, a free-running cycle
// counter with a read snapshot, and a sticky program-stop flag.
// Optional RX FIFO is compiled in when MEM_IO_RX_FIFO_EN is defined.
module mem_io_responder #(
  parameter int unsigned RAM_AW       = 17,
  parameter int unsigned TX_DEPTH_LOG = 3,
  parameter int unsigned RX_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE = 1;
  localparam logic [TX_DEPTH_LOG:0]   TX_CNT_ONE = 1;

  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CNT0 = 18'h30004;
  localparam logic [17:0] IO_CNT1 = 18'h30005;
  localparam logic [17:0] IO_CNT2 = 18'h30006;
  localparam logic [17:0] IO_CNT3 = 18'h30007;

  // Bus decode
  logic              is_io;
  logic [17:0]       io_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              rd_en;

  assign is_io   = (mem_a[17:16] == 2'b11);
  assign io_addr = mem_a[17:0];
  assign ram_idx = mem_a[RAM_AW-1:0];
  assign wr_en   = rdy_in & mem_wr;
  assign rd_en   = rdy_in & ~mem_wr;

  logic unused_addr;
  assign unused_addr = ^mem_a[31:18];

  // RAM storage (not reset)
  logic [7:0] ram_q [1 << RAM_AW];

  // RAM write port
  always_ff @(posedge clk_in) begin
    if (wr_en && !is_io) ram_q[ram_idx] <= mem_dout;
  end

  // Free-running cycle counter; only the upper 24 bits of the snapshot are
  // ever read back, byte 0 comes straight from the live counter.
  logic [31:0] cnt_q;
  logic [23:0] snap_q, snap_d;

  // Cycle counter ignores rdy_in
  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_q + 32'd1;
  end

  // RX side signals shared with the read mux
  logic       rx_nonempty;
  logic [7:0] rx_head;
  logic       rx_pop;

  // TX FIFO
  logic [7:0]              tx_mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_DEPTH_LOG:0]   tx_count_q;
  logic                    tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]              tx_push_data;
  logic                    stop_set, ovf_set;

  // CPU-side I/O write decode
  always_comb begin
    tx_push_req  = 1'b0;
    tx_push_data = mem_dout;
    stop_set     = 1'b0;
    if (wr_en && is_io) begin
      if (io_addr == IO_UART) begin
        tx_push_req = (mem_dout != 8'h00);
      end else if (io_addr == IO_CNT0) begin
        tx_push_req  = 1'b1;
        tx_push_data = '0;
        stop_set     = 1'b1;
      end
    end
  end

  assign tx_full        = tx_count_q[TX_DEPTH_LOG];
  assign tx_valid       = (tx_count_q != '0);
  assign tx_byte        = tx_mem_q[tx_rptr_q];
  assign tx_pop         = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign tx_push        = tx_push_req & (~tx_full | tx_pop);
  assign ovf_set        = tx_push_req & tx_full & ~tx_pop;
  assign io_buffer_full = (32'(tx_count_q) >= (TX_DEPTH - 2));

  // TX storage write
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_push_data;
  end

  // TX pointers, count and sticky flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_count_q  <= '0;
      prog_stop   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TX_PTR_ONE;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + TX_CNT_ONE;
        2'b01:   tx_count_q <= tx_count_q - TX_CNT_ONE;
        default: tx_count_q <= tx_count_q;
      endcase
      if (stop_set) prog_stop   <= 1'b1;
      if (ovf_set)  tx_overflow <= 1'b1;
    end
  end

  // Read data mux and snapshot capture
  logic [7:0] mem_din_q, mem_din_d;

  always_comb begin
    mem_din_d = mem_din_q;
    snap_d    = snap_q;
    rx_pop    = 1'b0;
    if (rd_en) begin
      if (!is_io) begin
        mem_din_d = ram_q[ram_idx];
      end else begin
        case (io_addr)
          IO_UART: begin
            mem_din_d = rx_nonempty ? rx_head : 8'h00;
            rx_pop    = rx_nonempty;
          end
          IO_CNT0: begin
            mem_din_d = cnt_q[7:0];
            snap_d    = cnt_q[31:8];
          end
          IO_CNT1: mem_din_d = snap_q[7:0];
          IO_CNT2: mem_din_d = snap_q[15:8];
          IO_CNT3: mem_din_d = snap_q[23:16];
          default: mem_din_d = '0;
        endcase
      end
    end
  end

  // Read data and snapshot registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din_q <= '0;
      snap_q    <= '0;
    end else begin
      mem_din_q <= mem_din_d;
      snap_q    <= snap_d;
    end
  end

  assign mem_din = mem_din_q;

`ifdef MEM_IO_RX_FIFO_EN
  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE = 1;
  localparam logic [RX_DEPTH_LOG:0]   RX_CNT_ONE = 1;

  logic [7:0]              rx_mem_q [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_DEPTH_LOG:0]   rx_count_q;
  logic                    rx_push;

  assign rx_ready    = ~rx_count_q[RX_DEPTH_LOG];
  assign rx_push     = rx_valid & rx_ready;
  assign rx_nonempty = (rx_count_q != '0);
  assign rx_head     = rx_mem_q[rx_rptr_q];

  // RX storage write (UART side, independent of rdy_in)
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_byte;
  end

  // RX pointers and count
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + RX_PTR_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + RX_CNT_ONE;
        2'b01:   rx_count_q <= rx_count_q - RX_CNT_ONE;
        default: rx_count_q <= rx_count_q;
      endcase
    end
  end
`else
  assign rx_ready    = 1'b0;
  assign rx_nonempty = 1'b0;
  assign rx_head     = '0;

  logic unused_rx;
  assign unused_rx = ^{rx_byte, rx_valid, rx_pop, RX_DEPTH_LOG};
`endif

endmodule
